// File: rtl/shiftregister_cfg_ctrl_if.sv
// Host handshake and PLL configuration chain signals for shiftregister_cfg_ctrl.
// The slave modport is the controller; the master modport is the host/chain side.
interface shiftregister_cfg_ctrl_if #(
  parameter int N = 100
);
  logic [N-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         rb_valid_in;
  logic         rb_ready;
  logic [N-1:0] rb_data;
  logic         rb_valid;
  logic         busy;
  logic         done;
  logic         sr_shift_en;
  logic         sr_s_in;
  logic         sr_s_out;
  logic         sr_load;
  logic         sr_read;

  modport slave (
    input  cfg_data, cfg_valid, rb_valid_in, sr_s_out,
    output cfg_ready, rb_ready, rb_data, rb_valid, busy, done,
           sr_shift_en, sr_s_in, sr_load, sr_read
  );

  modport master (
    output cfg_data, cfg_valid, rb_valid_in, sr_s_out,
    input  cfg_ready, rb_ready, rb_data, rb_valid, busy, done,
           sr_shift_en, sr_s_in, sr_load, sr_read
  );
endinterface

// File: rtl/shiftregister_cfg_ctrl.sv
// Write/readback sequencer for the N-bit PLL configuration shift chain.
// Optional CFGCTL_CLKDIV_EN: chain steps advance only on a prescaler tick every DIV clocks.
//
// state    | meaning
// S_IDLE   | ready for a write (priority) or readback request
// S_WSHIFT | shift N config bits into the chain, bit 0 first
// S_WLOAD  | one load strobe commits the chain to the config outputs
// S_RCAP   | one read strobe captures status into the chain
// S_RSHIFT | shift N status bits out, recirculating them into the chain
// S_FIN    | one-cycle done (plus rb_valid after a readback)
module shiftregister_cfg_ctrl #(
  parameter int N   = 100,
  parameter int DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  shiftregister_cfg_ctrl_if.slave  ctl
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_WSHIFT, S_WLOAD, S_RCAP, S_RSHIFT, S_FIN
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] tx_q, tx_d;
  logic [N-1:0] rx_q, rx_d;
  logic [N-1:0] rb_data_q, rb_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         is_rb_q, is_rb_d;
  logic         tick;
  logic         last_bit;

  logic         cfg_ready_o, rb_ready_o, rb_valid_o, busy_o, done_o;
  logic         shift_en_o, s_in_o, load_o, read_o;

`ifdef CFGCTL_CLKDIV_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;

  // Held at zero in IDLE so the first step of every operation is a full DIV period.
  always_comb begin
    presc_d = presc_q;
    if (state_q == S_IDLE || presc_q == PW'(DIV - 1)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = (presc_q == PW'(DIV - 1));
`else
  assign tick = 1'b1;
`endif

  assign last_bit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rb_data_d   = rb_data_q;
    cnt_d       = cnt_q;
    is_rb_d     = is_rb_q;
    cfg_ready_o = 1'b0;
    rb_ready_o  = 1'b0;
    rb_valid_o  = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    shift_en_o  = 1'b0;
    s_in_o      = 1'b0;
    load_o      = 1'b0;
    read_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_o      = 1'b0;
        cfg_ready_o = 1'b1;
        rb_ready_o  = ~ctl.cfg_valid;
        if (ctl.cfg_valid) begin
          tx_d    = ctl.cfg_data;
          cnt_d   = '0;
          is_rb_d = 1'b0;
          state_d = S_WSHIFT;
        end else if (ctl.rb_valid_in) begin
          cnt_d   = '0;
          is_rb_d = 1'b1;
          state_d = S_RCAP;
        end
      end
      S_WSHIFT: begin
        shift_en_o = tick;
        s_in_o     = tx_q[0];
        if (tick) begin
          tx_d = tx_q >> 1;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = S_WLOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WLOAD: begin
        shift_en_o = tick;
        load_o     = 1'b1;
        if (tick) state_d = S_FIN;
      end
      S_RCAP: begin
        shift_en_o = tick;
        read_o     = 1'b1;
        if (tick) state_d = S_RSHIFT;
      end
      S_RSHIFT: begin
        // Recirculate so the chain still holds the captured status afterwards.
        shift_en_o = tick;
        s_in_o     = ctl.sr_s_out;
        if (tick) begin
          rx_d = {ctl.sr_s_out, rx_q[N-1:1]};
          if (last_bit) begin
            rb_data_d = {ctl.sr_s_out, rx_q[N-1:1]};
            cnt_d     = '0;
            state_d   = S_FIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        done_o     = 1'b1;
        rb_valid_o = is_rb_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rb_data_q <= '0;
      cnt_q     <= '0;
      is_rb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rb_data_q <= rb_data_d;
      cnt_q     <= cnt_d;
      is_rb_q   <= is_rb_d;
    end
  end

  assign ctl.cfg_ready   = cfg_ready_o;
  assign ctl.rb_ready    = rb_ready_o;
  assign ctl.rb_data     = rb_data_q;
  assign ctl.rb_valid    = rb_valid_o;
  assign ctl.busy        = busy_o;
  assign ctl.done        = done_o;
  assign ctl.sr_shift_en = shift_en_o;
  assign ctl.sr_s_in     = s_in_o;
  assign ctl.sr_load     = load_o;
  assign ctl.sr_read     = read_o;

endmodule

// File: tb/tb_shiftregister_cfg_ctrl.sv
// Bench for shiftregister_cfg_ctrl with N=8 and a behavioural configuration chain attached.
// Define CFGCTL_CLKDIV_EN to run the divided-strobe scenario instead of the default set.
module tb_shiftregister_cfg_ctrl;
  localparam int N = 8;
`ifdef CFGCTL_CLKDIV_EN
  localparam int DIV = 3;
`else
  localparam int DIV = 4;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  shiftregister_cfg_ctrl_if #(.N(N)) ctl ();

  shiftregister_cfg_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (ctl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural chain: shifts toward bit 0 on enabled edges, load commits, read captures.
  logic [N-1:0] chain_q = '0;
  logic [N-1:0] cfg_out_q = '0;
  logic [N-1:0] s_hist = '0;
  logic [N-1:0] status_in = '0;
  int load_cnt = 0;

  always @(posedge clk) begin
    if (ctl.sr_shift_en) begin
      if (ctl.sr_load) begin
        cfg_out_q <= chain_q;
        load_cnt  <= load_cnt + 1;
      end else if (ctl.sr_read) begin
        chain_q <= status_in;
      end else begin
        chain_q <= {ctl.sr_s_in, chain_q[N-1:1]};
        s_hist  <= {s_hist[N-2:0], ctl.sr_s_in};
      end
    end
  end
  assign ctl.sr_s_out = chain_q[0];

  // Transaction-level model: operation kind and cycles elapsed since the accept edge.
  int m_op = 0;
  int m_off = 0;
  logic [N-1:0] m_word = '0;
  logic [N-1:0] m_rb = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_op  <= 0;
      m_off <= 0;
      m_rb  <= '0;
    end else if (m_op == 0) begin
      if (ctl.cfg_valid) begin
        m_op <= 1; m_off <= 1; m_word <= ctl.cfg_data;
      end else if (ctl.rb_valid_in) begin
        m_op <= 2; m_off <= 1; m_word <= status_in;
      end
    end else begin
      if (m_op == 2 && m_off == N + 1) m_rb <= m_word;
      if (m_off == N + 2) begin
        m_op <= 0; m_off <= 0;
      end else begin
        m_off <= m_off + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h cycle=%0d", name, got, exp, cyc);
    end
  endtask

`ifndef CFGCTL_CLKDIV_EN
  // Bit order: busy cfg_ready rb_ready done rb_valid shift_en s_in load read
  logic [8:0]   e_vec, g_vec, m_vec;
  logic [N-1:0] bitsel;
  always @(negedge clk) begin
    e_vec = '0;
    m_vec = '1;
    bitsel = '0;
    if (m_op == 0) begin
      e_vec[7] = 1'b1;
      e_vec[6] = ~ctl.cfg_valid;
    end else begin
      e_vec[8] = 1'b1;
      if (m_op == 1) begin
        if (m_off <= N) begin
          bitsel = m_word >> (m_off - 1);
          e_vec[3] = 1'b1; e_vec[2] = bitsel[0];
        end else if (m_off == N + 1) begin
          e_vec[3] = 1'b1; e_vec[1] = 1'b1;
        end else begin
          e_vec[5] = 1'b1;
        end
      end else begin
        if (m_off == 1) begin
          e_vec[3] = 1'b1; e_vec[0] = 1'b1; m_vec[2] = 1'b0;
        end else if (m_off <= N + 1) begin
          bitsel = m_word >> (m_off - 2);
          e_vec[3] = 1'b1; e_vec[2] = bitsel[0];
        end else begin
          e_vec[5] = 1'b1; e_vec[4] = 1'b1;
        end
      end
    end
    g_vec = {ctl.busy, ctl.cfg_ready, ctl.rb_ready, ctl.done, ctl.rb_valid,
             ctl.sr_shift_en, ctl.sr_s_in, ctl.sr_load, ctl.sr_read};
    check("outputs", 32'(g_vec & m_vec), 32'(e_vec & m_vec));
    check("rb_data", 32'(ctl.rb_data), 32'(m_rb));
  end
`endif

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ctl.done) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int k, at, at2, l0;
  int en_seen, en_bad;

  initial begin
    ctl.cfg_data    = '0;
    ctl.cfg_valid   = 1'b0;
    ctl.rb_valid_in = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check("reset_busy", 32'(ctl.busy), 32'd0);
    check("reset_cfg_ready", 32'(ctl.cfg_ready), 32'd1);
    check("reset_shift_en", 32'(ctl.sr_shift_en), 32'd0);

`ifndef CFGCTL_CLKDIV_EN
    // Write 0xA5
    l0 = load_cnt;
    step();
    ctl.cfg_data = 8'hA5; ctl.cfg_valid = 1'b1; k = cyc;
    step();
    ctl.cfg_valid = 1'b0;
    wait_done(at);
    check("wr_latency", 32'(at), 32'(k + 10));
    check("wr_cfg_out", 32'(cfg_out_q), 32'h A5);
    check("wr_serial", 32'(s_hist), 32'h A5);
    check("wr_loads", 32'(load_cnt - l0), 32'd1);

    // Readback of status 0x3C
    status_in = 8'h3C;
    step();
    ctl.rb_valid_in = 1'b1; k = cyc;
    step();
    ctl.rb_valid_in = 1'b0;
    wait_done(at);
    check("rb_latency", 32'(at), 32'(k + 10));
    check("rb_valid_pulse", 32'(ctl.rb_valid), 32'd1);
    check("rb_word", 32'(ctl.rb_data), 32'h3C);
    check("rb_chain_kept", 32'(chain_q), 32'h3C);

    // Reset in the middle of a write shift
    l0 = load_cnt;
    step();
    ctl.cfg_data = 8'h33; ctl.cfg_valid = 1'b1;
    step();
    ctl.cfg_valid = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("abort_shift_en", 32'(ctl.sr_shift_en), 32'd0);
    check("abort_busy", 32'(ctl.busy), 32'd0);
    check("abort_rb_data", 32'(ctl.rb_data), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("abort_cfg_ready", 32'(ctl.cfg_ready), 32'd1);
    check("abort_no_load", 32'(load_cnt - l0), 32'd0);
    check("abort_cfg_out", 32'(cfg_out_q), 32'h A5);

    // Simultaneous write and readback requests
    status_in = 8'hC3;
    ctl.cfg_data = 8'h5A; ctl.cfg_valid = 1'b1; ctl.rb_valid_in = 1'b1; k = cyc;
    @(negedge clk);
    check("collide_rb_ready", 32'(ctl.rb_ready), 32'd0);
    check("collide_cfg_ready", 32'(ctl.cfg_ready), 32'd1);
    step();
    ctl.cfg_valid = 1'b0;
    wait_done(at);
    check("collide_wr_latency", 32'(at), 32'(k + 10));
    check("collide_rb_valid_on_wr", 32'(ctl.rb_valid), 32'd0);
    step();
    step();
    ctl.rb_valid_in = 1'b0;
    wait_done(at2);
    check("collide_rd_latency", 32'(at2), 32'(at + 11));
    check("collide_cfg_out", 32'(cfg_out_q), 32'h5A);
    check("collide_rb_word", 32'(ctl.rb_data), 32'hC3);

    // Back-to-back writes with cfg_valid held
    l0 = load_cnt;
    step();
    ctl.cfg_data = 8'hFF; ctl.cfg_valid = 1'b1;
    wait_done(at);
    check("b2b_first", 32'(cfg_out_q), 32'hFF);
    step();
    ctl.cfg_data = 8'h00;
    step();
    ctl.cfg_valid = 1'b0;
    wait_done(at2);
    check("b2b_spacing", 32'(at2), 32'(at + 11));
    check("b2b_second", 32'(cfg_out_q), 32'h00);
    check("b2b_loads", 32'(load_cnt - l0), 32'd2);
    repeat (3) step();
`else
    // Divided strobes: DIV=3, write 0x81
    l0 = load_cnt;
    en_seen = 0;
    en_bad = 0;
    step();
    ctl.cfg_data = 8'h81; ctl.cfg_valid = 1'b1; k = cyc;
    step();
    ctl.cfg_valid = 1'b0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ctl.sr_shift_en) begin
        en_seen++;
        if ((cyc - k) % 3 != 0) en_bad++;
      end
      if (ctl.done && at < 0) at = cyc;
    end
    check("div_enables", 32'(en_seen), 32'd9);
    check("div_spacing", 32'(en_bad), 32'd0);
    check("div_latency", 32'(at), 32'(k + 28));
    check("div_cfg_out", 32'(cfg_out_q), 32'h81);
    check("div_loads", 32'(load_cnt - l0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
